mc_main_control: RTL and testbench
==================================

Name: mc_main_control

Overview:
- Multi-cycle main control FSM for the MIPS datapath; sits directly upstream of the ALU control decoder.
- Decodes the 6-bit opcode and steps each instruction through fetch/decode/execute/memory/writeback states.
- Drives every datapath enable, every mux select and the 2-bit ALUOp consumed by the ALU control decoder.
- Stalls on a memory-ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- JR_FUNCT, 6'd8, funct code identifying jr inside R-format

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- op  input  6  instruction[31:26] from IR
- funct  input  6  instruction[5:0] from IR (jr detection only)
- mem_ready  input  1  memory completes current read/write this cycle
- PCWrite  output  1  unconditional PC load
- PCWriteCond  output  1  PC load if ALU zero
- IorD  output  1  0=PC, 1=ALUOut address
- MemRead  output  1  memory read request
- MemWrite  output  1  memory write request
- IRWrite  output  1  instruction register load
- MemtoReg  output  1  1=MDR writeback
- RegDst  output  1  1=rd, 0=rt
- RegWrite  output  1  register file write
- ALUSrcA  output  1  0=PC, 1=A
- ALUSrcB  output  2  00=B, 01=4, 10=signext imm, 11=imm<<2
- ALUOp  output  2  00 add, 01 sub, 10 funct-decode
- PCSource  output  2  00=ALU, 01=ALUOut, 10=jump addr, 11=A (jr)
- state_o  output  4  current state, debug
- instr_count  output  CNT_W  retired instructions
- illegal  output  1  sticky illegal-opcode flag (0 unless ILLEGAL_TRAP_EN)

Behaviour:
- Reset (async, any cycle, mid-instruction included): state=FETCH(0), instr_count=0, illegal=0, every control output forced 0 while reset is high. First fetch starts in the first cycle after deassertion.
- Outputs are Moore decode of the state register, except IRWrite/PCWrite in FETCH, which are qualified by mem_ready. Any output not listed for a state is 0.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- State encodings are 4 bits: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, JR 12, TRAP 13.
- FETCH: MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready. Hold until mem_ready, then DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - lw/sw -> MEMADR
  - R with funct==JR_FUNCT -> JR; other R -> EXEC
  - beq -> BRANCH
  - j -> JUMP
  - addi -> ADDIEX
  - other -> see Optional Feature
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: MemRead, IorD=1. Hold until mem_ready, then MEMWB.
- MEMWB: RegWrite, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR: MemWrite, IorD=1. Hold until mem_ready, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegWrite, RegDst=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01 -> FETCH.
- JUMP: PCWrite, PCSource=10 -> FETCH.
- JR: ALUSrcA=1, ALUOp=10, PCWrite, PCSource=11 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegWrite, RegDst=0, MemtoReg=0 -> FETCH.
- Latencies, FETCH to FETCH with zero-wait memory: lw 5 cycles; sw, R, addi 4; beq, j, jr 3. Each cycle mem_ready stays low adds one cycle.
- instr_count increments (modulo 2^CNT_W, wraps silently) on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, JUMP, JR or ADDIWB.
- mem_ready is ignored in states that do not wait on it.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP. TRAP drives all control outputs 0, sets illegal=1 and holds until reset; the instruction is not counted.
- Undefined: an unknown opcode in DECODE -> FETCH as a nop (not counted); no TRAP state exists; illegal is tied 0.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - state enum/localparams (4-bit)
  - ALUOp encodings, shared with the ALU control decoder
  - ALUSrcB and PCSource select encodings
- One natural sub-module: mc_ctrl_decode, a combinational state -> control-word decode. The FSM register, next-state logic and counter stay in the top.

Test Plan:
- Reset mid-MEMRD with mem_ready=0 -> all outputs 0 immediately, asynchronously; after release state_o=0, instr_count=0.
- lw (op=100011), mem_ready always 1 -> states 0,1,2,3,4,0; MEMWB shows RegWrite=1, MemtoReg=1; instr_count 0->1.
- R add (funct=100000) -> EXEC shows ALUOp=10, ALUSrcA=1; ALUWB shows RegDst=1, RegWrite=1; 4 cycles.
- jr (op=0, funct=8) -> JR shows PCWrite=1, PCSource=11; beq shows ALUOp=01, PCWriteCond=1, PCSource=01.
- sw with mem_ready low 3 cycles in FETCH and 2 in MEMWR -> 9 cycles total; IRWrite pulses exactly once.
- op=111111 -> with ILLEGAL_TRAP_EN: state 13, illegal=1 held, count unchanged; without it: back to FETCH, illegal=0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control and the ALU control decoder.
// The TRAP state only exists when ILLEGAL_TRAP_EN is defined.
package mips_ctrl_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StAddiEx = 4'd10,
    StAddiWb = 4'd11,
    StJr     = 4'd12
`ifdef ILLEGAL_TRAP_EN
    ,
    StTrap   = 4'd13
`endif
  } state_e;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [1:0] SrcBReg   = 2'b00;
  localparam logic [1:0] SrcBFour  = 2'b01;
  localparam logic [1:0] SrcBImm   = 2'b10;
  localparam logic [1:0] SrcBImmSh = 2'b11;

  localparam logic [1:0] PcSrcAlu    = 2'b00;
  localparam logic [1:0] PcSrcAluOut = 2'b01;
  localparam logic [1:0] PcSrcJump   = 2'b10;
  localparam logic [1:0] PcSrcReg    = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States whose exit into FETCH retires an instruction.
  function automatic logic is_retire(state_e s);
    return s inside {StMemWb, StMemWr, StAluWb, StBranch, StJump, StJr, StAddiWb};
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> control-word decode for the multi-cycle main control.
// TRAP (ILLEGAL_TRAP_EN builds) falls through to the all-zero default.
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SrcBFour;
        ctrl_o.alu_op    = AluOpAdd;
        ctrl_o.pc_source = PcSrcAlu;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      StDecode: begin
        ctrl_o.alu_src_b = SrcBImmSh;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemAdr, StAddiEx: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBImm;
        ctrl_o.alu_op    = AluOpAdd;
      end
      StMemRd: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      StMemWr: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      StExec: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SrcBReg;
        ctrl_o.alu_op    = AluOpFunct;
      end
      StAluWb: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      StBranch: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SrcBReg;
        ctrl_o.alu_op        = AluOpSub;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PcSrcAluOut;
      end
      StJump: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PcSrcJump;
      end
      StJr: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = AluOpFunct;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PcSrcReg;
      end
      StAddiWb: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM with memory-ready stalls and retired-instruction counter.
// ILLEGAL_TRAP_EN: unknown opcodes enter a sticky TRAP state instead of acting as a nop.
module mc_main_control
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter logic [5:0]  JR_FUNCT = 6'd8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctrl_t            ctrl, ctrl_g;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_ready) state_d = StDecode;
      StDecode: begin
        if (op == OpLw || op == OpSw) begin
          state_d = StMemAdr;
        end else if (op == OpRtype) begin
          state_d = (funct == JR_FUNCT) ? StJr : StExec;
        end else if (op == OpBeq) begin
          state_d = StBranch;
        end else if (op == OpJ) begin
          state_d = StJump;
        end else if (op == OpAddi) begin
          state_d = StAddiEx;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = StTrap;
`else
          state_d = StFetch;
`endif
        end
      end
      // IR still holds the opcode, so lw/sw split is re-decoded here.
      StMemAdr: state_d = (op == OpSw) ? StMemWr : StMemRd;
      StMemRd:  if (mem_ready) state_d = StMemWb;
      StMemWr:  if (mem_ready) state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StBranch, StJump, StJr, StAddiWb: state_d = StFetch;
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (state_d == StFetch && is_retire(state_q)) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StFetch;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  always_comb begin
    illegal_d = illegal_q;
    if (state_d == StTrap) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  // State resets to FETCH, whose decode is non-zero; mask outputs while reset is held.
  assign ctrl_g = reset ? '0 : ctrl;

  assign PCWrite     = ctrl_g.pc_write;
  assign PCWriteCond = ctrl_g.pc_write_cond;
  assign IorD        = ctrl_g.i_or_d;
  assign MemRead     = ctrl_g.mem_read;
  assign MemWrite    = ctrl_g.mem_write;
  assign IRWrite     = ctrl_g.ir_write;
  assign MemtoReg    = ctrl_g.mem_to_reg;
  assign RegDst      = ctrl_g.reg_dst;
  assign RegWrite    = ctrl_g.reg_write;
  assign ALUSrcA     = ctrl_g.alu_src_a;
  assign ALUSrcB     = ctrl_g.alu_src_b;
  assign ALUOp       = ctrl_g.alu_op;
  assign PCSource    = ctrl_g.pc_source;
  assign state_o     = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: table of instruction traces plus stall/reset/illegal cases.
module tb_mc_main_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state_o;
  logic [31:0] instr_count;
  logic        illegal;

  mc_main_control #(.CNT_W(32), .JR_FUNCT(6'd8)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .state_o     (state_o),
    .instr_count (instr_count),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]         op;
    logic [5:0]         funct;
    int                 n;
    logic [0:9][3:0]    seq;
    logic [0:9]         mr;
    bit                 counted;
  } vec_t;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ir_pulses = 0;
  logic [31:0] exp_count = 0;
  vec_t        vecs[7];

  wire [15:0] act_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                          RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  // Expected control word, packed in the same order as act_ctrl.
  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
    logic pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa;
    logic [1:0] sb_, aop, pcs;
    {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
    sb_ = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      4'd0:  begin mrd = 1; sb_ = 2'b01; irw = mr; pw = mr; end
      4'd1:  sb_ = 2'b11;
      4'd2:  begin sa = 1; sb_ = 2'b10; end
      4'd3:  begin mrd = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mwr = 1; iord = 1; end
      4'd6:  begin sa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rdst = 1; end
      4'd8:  begin sa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; end
      4'd9:  begin pw = 1; pcs = 2'b10; end
      4'd10: begin sa = 1; sb_ = 2'b10; end
      4'd11: rw = 1;
      4'd12: begin sa = 1; aop = 2'b10; pw = 1; pcs = 2'b11; end
      default: ;
    endcase
    return {pw, pwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb_, aop, pcs};
  endfunction

  function automatic vec_t mkv(input logic [5:0] o, input logic [5:0] f, input int n,
                               input logic [0:9][3:0] s, input logic [0:9] m, input bit c);
    vec_t v;
    v.op = o; v.funct = f; v.n = n; v.seq = s; v.mr = m; v.counted = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Drives one instruction: expected per-cycle states are queued, then popped cycle by cycle.
  task automatic run(input vec_t v);
    exp_t e;
    op = v.op;
    funct = v.funct;
    for (int i = 0; i < v.n; i++) sb.push_back('{st: v.seq[i], mr: v.mr[i]});
    for (int i = 0; i < v.n; i++) begin
      @(negedge clk);
      mem_ready = v.mr[i];
      #1;
      e = sb.pop_front();
      chk("state", 32'(state_o), 32'(e.st));
      chk("ctrl", 32'(act_ctrl), 32'(exp_ctrl(e.st, e.mr)));
      chk("illegal", 32'(illegal), 32'(e.st == 4'd13));
      if (IRWrite) ir_pulses++;
    end
    @(posedge clk);
    #1;
    if (v.counted) exp_count++;
    chk("instr_count", instr_count, exp_count);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = mkv(6'b100011, 6'd0,  5, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 20'd0}, 10'h3ff, 1);
    vecs[1] = mkv(6'b000000, 6'h20, 4, {4'd0, 4'd1, 4'd6, 4'd7, 24'd0}, 10'h3ff, 1);
    vecs[2] = mkv(6'b000000, 6'd8,  3, {4'd0, 4'd1, 4'd12, 28'd0}, 10'h3ff, 1);
    vecs[3] = mkv(6'b000100, 6'd0,  3, {4'd0, 4'd1, 4'd8, 28'd0}, 10'h3ff, 1);
    vecs[4] = mkv(6'b000010, 6'd0,  3, {4'd0, 4'd1, 4'd9, 28'd0}, 10'h3ff, 1);
    vecs[5] = mkv(6'b001000, 6'd0,  4, {4'd0, 4'd1, 4'd10, 4'd11, 24'd0}, 10'h3ff, 1);
    vecs[6] = mkv(6'b101011, 6'd0,  4, {4'd0, 4'd1, 4'd2, 4'd5, 24'd0}, 10'h3ff, 1);

    reset = 1'b1; op = '0; funct = '0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", 32'(act_ctrl), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_count", instr_count, 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);

    for (int k = 0; k < 7; k++) run(vecs[k]);

    // sw with 3 FETCH waits and 2 MEMWR waits: 9 cycles, one IRWrite pulse.
    ir_pulses = 0;
    run(mkv(6'b101011, 6'd0, 9,
            {4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd0},
            10'b0001110010, 1));
    chk("sw_irwrite_pulses", 32'(ir_pulses), 32'd1);

    // Async reset in the middle of a stalled MEMRD.
    run(mkv(6'b100011, 6'd0, 4, {4'd0, 4'd1, 4'd2, 4'd3, 24'd0}, 10'b1110000000, 0));
    @(negedge clk);
    #1;
    chk("memrd_stall_state", 32'(state_o), 32'd3);
    reset = 1'b1;
    #1;
    chk("async_reset_ctrl", 32'(act_ctrl), 32'd0);
    chk("async_reset_state", 32'(state_o), 32'd0);
    chk("async_reset_count", instr_count, 32'd0);
    @(posedge clk);
    #1;
    chk("reset_held_ctrl", 32'(act_ctrl), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_count = 0;
    #1;
    chk("post_reset_state", 32'(state_o), 32'd0);
    chk("post_reset_count", instr_count, 32'd0);

    run(vecs[0]);

`ifdef ILLEGAL_TRAP_EN
    run(mkv(6'b111111, 6'd0, 5, {4'd0, 4'd1, 4'd13, 4'd13, 4'd13, 20'd0}, 10'h3ff, 0));
    chk("trap_illegal", 32'(illegal), 32'd1);
`else
    run(mkv(6'b111111, 6'd0, 2, {4'd0, 4'd1, 32'd0}, 10'h3ff, 0));
    chk("nop_illegal", 32'(illegal), 32'd0);
    run(vecs[1]);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
